// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forwarding select encodings and controller FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN,
    HZ_LU_STALL
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// One E-stage operand: compare against M/W destinations, M result has priority.
// Purely combinational, zero latency, no flow control.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  logic     match_m;
  logic     match_w;
  fwd_sel_t sel_e;

  // A hardwired zero register must never be treated as a producer.
  assign match_m = reg_write_m && (rs == rd_m) && !((ZERO_REG != 0) && (rd_m == '0));
  assign match_w = reg_write_w && (rs == rd_w) && !((ZERO_REG != 0) && (rd_w == '0));

  always_comb begin
    sel_e = FWD_RF;
    if (match_m) begin
      sel_e = FWD_MEM;
    end else if (match_w) begin
      sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: operand forwarding, load-use stall of LOAD_LAT cycles, branch flush, stall counter.
// Forward/stall/flush are same-cycle combinational; only FSM, latency and perf counters are registered.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int REG_AW   = 4,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] rs_d,
  input  logic [NUM_SRC-1:0]        src_used_d,
  input  logic [NUM_SRC*REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic                      reg_write_e,
  input  logic                      mem_to_reg_e,
  input  logic [REG_AW-1:0]         rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_AW-1:0]         rd_w,
  input  logic                      reg_write_w,
  input  logic                      branch_taken_e,
  input  logic                      perf_clr,
  output logic [2*NUM_SRC-1:0]      forward_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int LAT_W = $clog2(LOAD_LAT + 1);

  hz_state_t            state;
  hz_state_t            state_nxt;
  logic [LAT_W-1:0]     lat_cnt;
  logic [LAT_W-1:0]     lat_nxt;
  logic                 hit;
  logic [2*NUM_SRC-1:0] fwd_raw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_fwd (
      .rs          (rs_e[i*REG_AW +: REG_AW]),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .sel         (fwd_raw[2*i +: 2])
    );
  end

  assign forward_e = rst ? '0 : fwd_raw;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used_d[i] && (rs_d[i*REG_AW +: REG_AW] == rd_e)) begin
        hit = 1'b1;
      end
    end
    if (!reg_write_e || !mem_to_reg_e || ((ZERO_REG != 0) && (rd_e == '0))) begin
      hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HZ_RUN;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // The first stall cycle is spent in RUN, so LU_STALL covers the remaining LOAD_LAT-1.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    if (branch_taken_e) begin
      state_nxt = HZ_RUN;
      lat_nxt   = '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (hit && (LOAD_LAT > 1)) begin
            state_nxt = HZ_LU_STALL;
            lat_nxt   = LAT_W'(LOAD_LAT - 1);
          end
        end
        HZ_LU_STALL: begin
          lat_nxt = lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state_nxt = HZ_RUN;
          end
        end
        default: begin
          state_nxt = HZ_RUN;
          lat_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if ((state == HZ_LU_STALL) || hit) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
    end else if (stall_d && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit with LOAD_LAT=3, CNT_W=4, ZERO_REG=1.
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl_unit;

  localparam int NS = 3;
  localparam int AW = 4;
  localparam int LL = 3;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*AW-1:0] rs_d, rs_e;
  logic [NS-1:0]  src_used_d;
  logic [AW-1:0]  rd_e, rd_m, rd_w;
  logic           reg_write_e, mem_to_reg_e, reg_write_m, reg_write_w;
  logic           branch_taken_e, perf_clr;
  logic [2*NS-1:0] forward_e;
  logic           stall_f, stall_d, flush_d, flush_e;
  logic [CW-1:0]  stall_count;
  logic [13:0]    obs;

  int n_cmp = 0;
  int n_err = 0;
  int m_rem = 0;
  int m_cnt = 0;

  hazard_ctrl_unit #(
    .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(LL), .ZERO_REG(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .src_used_d(src_used_d), .rs_e(rs_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .branch_taken_e(branch_taken_e), .perf_clr(perf_clr), .forward_e(forward_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign obs = {forward_e, stall_f, stall_d, flush_d, flush_e, stall_count};

  // Reference model: a load-use hit owes LL stall cycles; m_rem counts the ones still owed.
  function automatic logic ref_hit();
    logic h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (src_used_d[i] && rs_d[i*AW +: AW] == rd_e) h = 1'b1;
    return h && reg_write_e && mem_to_reg_e && (rd_e != 0);
  endfunction

  function automatic logic [13:0] model_out();
    logic [5:0] f = '0;
    logic es = 1'b0, efd = 1'b0, efe = 1'b0;
    logic [AW-1:0] a;
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        a = rs_e[i*AW +: AW];
        if (reg_write_m && a == rd_m && rd_m != 0)      f[2*i +: 2] = 2'd2;
        else if (reg_write_w && a == rd_w && rd_w != 0) f[2*i +: 2] = 2'd1;
      end
      if (branch_taken_e) begin
        efd = 1'b1;
        efe = 1'b1;
      end else begin
        es  = (m_rem > 0) || ref_hit();
        efe = es;
      end
    end
    return {f, es, es, efd, efe, 4'(m_cnt)};
  endfunction

  task automatic model_tick();
    logic es;
    if (rst) begin
      m_rem = 0;
      m_cnt = 0;
      return;
    end
    es = !branch_taken_e && ((m_rem > 0) || ref_hit());
    if (perf_clr) m_cnt = 0;
    else if (es && m_cnt < 15) m_cnt++;
    if (branch_taken_e) m_rem = 0;
    else if (m_rem > 0) m_rem--;
    else if (ref_hit()) m_rem = LL - 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    rs_d = '0; rs_e = '0; src_used_d = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 0; mem_to_reg_e = 0; reg_write_m = 0; reg_write_w = 0;
    branch_taken_e = 0; perf_clr = 0;
  endtask

  task automatic set_load(input logic [AW-1:0] rd, input logic [NS-1:0] used);
    rd_e = rd; reg_write_e = 1; mem_to_reg_e = 1;
    rs_d = {rd, 4'd1, 4'd2};
    src_used_d = used;
  endtask

  task automatic clr_count();
    perf_clr = 1;
    tick();
    perf_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; m_rem = 0; m_cnt = 0;
    set_load(4'd7, 3'b100);
    rs_e = 12'h555; rd_m = 5; reg_write_m = 1;
    #3;
    n_cmp++;
    if (obs !== 14'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    tick();
    n_cmp++;
    if (obs !== 14'd0) begin n_err++; $display("FAIL reset_hold: got %h want 0", obs); end
    idle();
    rst = 0;
    tick();
  endtask

  task automatic test_forward();
    idle();
    rs_e = {4'd9, 4'd10, 4'd5}; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    @(negedge clk);
    n_cmp++;
    if (forward_e !== 6'b000010) begin n_err++; $display("FAIL fwd_m_prio: got %b want 000010", forward_e); end
    reg_write_m = 0;
    #1;
    n_cmp++;
    if (forward_e !== 6'b000001) begin n_err++; $display("FAIL fwd_w_only: got %b want 000001", forward_e); end
    rs_e = {4'd3, 4'd0, 4'd3}; rd_m = 0; reg_write_m = 1; rd_w = 3; reg_write_w = 1;
    #1;
    n_cmp++;
    if (forward_e !== 6'b010001) begin n_err++; $display("FAIL fwd_zero_reg: got %b want 010001", forward_e); end
    tick();
  endtask

  task automatic test_zero_load();
    idle();
    set_load(4'd0, 3'b111);
    rs_d = '0;
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
      n_err++; $display("FAIL zero_load_stall: got stall_d=%b flush_e=%b want 0 0", stall_d, flush_e);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    idle();
    clr_count();
    set_load(4'd7, 3'b100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_f, stall_d, flush_e} !== {3{k < LL}}) begin
        n_err++; $display("FAIL lu_stall_c%0d: got %b want %b", k, {stall_f, stall_d, flush_e}, {3{k < LL}});
      end
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL lu_model_c%0d: got %h want %h", k, obs, model_out()); end
      tick();
      if (k == 0) idle();
    end
    n_cmp++;
    if (stall_count !== 4'd3) begin n_err++; $display("FAIL lu_count: got %0d want 3", stall_count); end
    set_load(4'd7, 3'b000);
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b0) begin n_err++; $display("FAIL lu_unused_src: got %b want 0", stall_d); end
    tick();
    idle();
  endtask

  task automatic test_branch_cancel();
    idle();
    clr_count();
    set_load(4'd7, 3'b100);
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b1) begin n_err++; $display("FAIL br_first_stall: got %b want 1", stall_d); end
    tick();
    idle();
    branch_taken_e = 1;
    @(negedge clk);
    n_cmp++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      n_err++; $display("FAIL br_cancel: got %b want 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    branch_taken_e = 0;
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b0 || stall_count !== 4'd1) begin
      n_err++; $display("FAIL br_after: got stall_d=%b count=%0d want 0 1", stall_d, stall_count);
    end
    tick();
  endtask

  task automatic test_rst_mid_stall();
    idle();
    set_load(4'd7, 3'b100);
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b1) begin n_err++; $display("FAIL rst_in_stall: got %b want 1", stall_d); end
    rst = 1; m_rem = 0; m_cnt = 0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin n_err++; $display("FAIL rst_mid_outputs: got %h want 0", obs); end
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (stall_d !== 1'b0 || obs !== model_out()) begin
        n_err++; $display("FAIL rst_release_c%0d: got %h want %h", k, obs, model_out());
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    idle();
    clr_count();
    set_load(4'd9, 3'b100);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL sat_model_c%0d: got %h want %h", k, obs, model_out()); end
      tick();
    end
    n_cmp++;
    if (stall_count !== 4'd15) begin n_err++; $display("FAIL sat_count: got %0d want 15", stall_count); end
    perf_clr = 1;
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b1) begin n_err++; $display("FAIL clr_stall_active: got %b want 1", stall_d); end
    tick();
    n_cmp++;
    if (stall_count !== 4'd0) begin n_err++; $display("FAIL clr_wins: got %0d want 0", stall_count); end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NS; i++) begin
        rs_d[i*AW +: AW] = 4'($urandom_range(0, 3));
        rs_e[i*AW +: AW] = 4'($urandom_range(0, 3));
      end
      src_used_d = 3'($urandom);
      rd_e = 4'($urandom_range(0, 3)); rd_m = 4'($urandom_range(0, 3)); rd_w = 4'($urandom_range(0, 3));
      reg_write_e = 1'($urandom); mem_to_reg_e = ($urandom_range(0, 2) != 0);
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      branch_taken_e = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      if (rst) begin m_rem = 0; m_cnt = 0; end
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL rand_c%0d: got %h want %h", k, obs, model_out()); end
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero_load();
    test_load_use();
    test_branch_cancel();
    test_rst_mid_stall();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
